// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: load/store opcodes,
// FSM state encoding and the byte-lane mask helper.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        FIN  = 3'd3,
        RESP = 3'd4
    } mem_state_t;

    // Unshifted byte enables for an access size (MemOp[1:0]); illegal sizes give none.
    function automatic logic [3:0] base_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bram.sv
// Single-port word-organised RAM with per-byte write enables and a
// registered (1-cycle) read port.
module data_mem_bram #(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose, so it maps onto block RAM;
    // sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: latches one request, splits misaligned accesses
// into two word accesses and returns a held, extended response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemWr,
    input  logic [2:0]  MemOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    mem_state_t state, state_next;

    logic          wr_q;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic          split_q;
    logic [31:0]   wdata_q;
    logic [31:0]   w0_q;

    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    // Request decode, evaluated only while idle.
    logic          accept;
    logic [1:0]    in_off;
    logic [AW-1:0] in_idx;
    logic          in_split;
    logic          in_err;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_off    = addr[1:0];
    assign in_idx    = addr[AW+1:2];
    assign in_split  = ((MemOp[1:0] == 2'b01) && (in_off == 2'b11)) ||
                       ((MemOp[1:0] == 2'b10) && (in_off != 2'b00));
    assign in_err    = ((addr >> (AW + 2)) != '0) ||
                       (in_split && (in_idx == AW'(DEPTH - 1))) ||
                       (MemOp inside {3'b011, 3'b110, 3'b111}) ||
                       (MemWr && MemOp[2]);

    // Store lanes span two words; the upper half only matters for split stores.
    logic [63:0] st_lanes;
    logic [7:0]  st_mask;

    assign st_lanes = {32'b0, wdata_q} << {off_q, 3'b000};
    assign st_mask  = {4'b0000, base_mask(op_q[1:0])} << off_q;

    // In FIN the RAM output is the last word read; for split loads w0 was saved in ACC1.
    logic [31:0] w0, w1, ld_word, ld_data;

    assign w0      = split_q ? w0_q : ram_rdata;
    assign w1      = split_q ? ram_rdata : 32'b0;
    assign ld_word = 32'({w1, w0} >> {off_q, 3'b000});

    always_comb begin
        case (op_q[1:0])
            2'b00:   ld_data = op_q[2] ? {24'b0, ld_word[7:0]}  : {{24{ld_word[7]}},  ld_word[7:0]};
            2'b01:   ld_data = op_q[2] ? {16'b0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ram_addr   = idx_q;
        ram_we     = 4'b0000;
        ram_wdata  = st_lanes[31:0];
        case (state)
            IDLE: if (accept) state_next = in_err ? RESP : ACC0;
            ACC0: begin
                if (wr_q) ram_we = st_mask[3:0];
                if (split_q)   state_next = ACC1;
                else if (wr_q) state_next = RESP;
                else           state_next = FIN;
            end
            ACC1: begin
                ram_addr  = idx_q + AW'(1);
                ram_wdata = st_lanes[63:32];
                if (wr_q) ram_we = st_mask[7:4];
                state_next = wr_q ? RESP : FIN;
            end
            FIN:  state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            op_q       <= 3'b000;
            off_q      <= 2'b00;
            idx_q      <= '0;
            split_q    <= 1'b0;
            wdata_q    <= 32'b0;
            w0_q       <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            resp_valid <= (state_next == RESP);
            if (accept) begin
                wr_q       <= MemWr;
                op_q       <= MemOp;
                off_q      <= in_off;
                idx_q      <= in_idx;
                split_q    <= in_split;
                wdata_q    <= wdata;
                resp_err   <= in_err;
                resp_rdata <= 32'b0;
            end
            if (state == ACC1 && !wr_q) w0_q <= ram_rdata;
            if (state == FIN) resp_rdata <= ld_data;
        end
    end

    data_mem_bram #(.DEPTH(DEPTH)) u_bram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
